// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake between the PS/2 receive FIFO and the key-matrix decoder.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [FIFO_AW:0] fifo_level;

    modport master (output rx_data, output rx_valid, output fifo_level, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input fifo_level, output rx_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 line synchroniser + glitch filter, 11-bit frame checker and byte FIFO with valid/ready pop.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master bus,
    output logic          frame_err,
    output logic          overflow
);
    localparam int unsigned FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]         r_clk_sync, r_dat_sync;
    logic [FCW-1:0]     r_clk_cnt, r_dat_cnt;
    logic               r_clk_f, r_dat_f, r_clk_f_d;
    state_t             r_state;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [TW-1:0]      r_timer;
    logic               r_push;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0]      r_level;
    logic               r_valid;
    logic [7:0]         r_head;

    logic               w_strobe, w_pop, w_full, w_wr;
    logic [FIFO_AW-1:0] w_rnext;
    logic [LW-1:0]      w_level_nxt;

    // Synchronise both lines, then only follow the synced level after FILTER_LEN equal samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_cnt  <= '0;
            r_dat_cnt  <= '0;
            r_clk_f    <= 1'b1;
            r_dat_f    <= 1'b1;
            r_clk_f_d  <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_f_d  <= r_clk_f;
            if (r_clk_sync[1] == r_clk_f) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == FCW'(FILTER_LEN - 1)) begin
                r_clk_f   <= r_clk_sync[1];
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (r_dat_sync[1] == r_dat_f) begin
                r_dat_cnt <= '0;
            end else if (r_dat_cnt == FCW'(FILTER_LEN - 1)) begin
                r_dat_f   <= r_dat_sync[1];
                r_dat_cnt <= '0;
            end else begin
                r_dat_cnt <= r_dat_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_clk_f_d & ~r_clk_f;

    // Frame FSM; the assembled byte stays in r_shift for the push cycle that follows STOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_timer   <= '0;
            r_push    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_push    <= 1'b0;
            frame_err <= 1'b0;
            if (r_state == S_IDLE) begin
                r_timer <= '0;
                if (w_strobe) begin
                    if (!r_dat_f) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (w_strobe) begin
                r_timer <= '0;
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {r_dat_f, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= r_dat_f;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        if (r_dat_f && (((^r_shift) ^ r_parity) == 1'b1)) r_push <= 1'b1;
                        else frame_err <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
                r_state   <= S_IDLE;
                r_timer   <= '0;
                frame_err <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign w_pop   = r_valid & bus.rx_ready;
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_rnext = r_rptr + FIFO_AW'(1);

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_pop)      w_level_nxt = r_level + LW'(1);
        else if (!w_wr && w_pop) w_level_nxt = r_level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    // Head register: next stored byte on pop, or the incoming byte when it lands in an empty FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_head   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            overflow <= r_push & w_full & ~w_pop;
            r_level  <= w_level_nxt;
            r_valid  <= (w_level_nxt != '0);
            if (w_wr)  r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop) r_rptr <= w_rnext;
            if (w_pop) begin
                if (r_level > LW'(1)) r_head <= r_mem[w_rnext];
                else if (w_wr)        r_head <= r_shift;
            end else if (w_wr && (r_level == '0)) begin
                r_head <= r_shift;
            end
        end
    end

    assign bus.rx_data    = r_head;
    assign bus.rx_valid   = r_valid;
    assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised PS/2 frame stimulus against a queue-based model of received bytes and error/overflow pulses.
module tb_ps2_rx_fifo;
    localparam int unsigned FIFO_AW = 3;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TMO     = 2000;
    localparam int          SETTLE  = 30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic rx_ready = 1'b0;
    logic frame_err, overflow;

    ps2_rx_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();
    assign bus.rx_ready = rx_ready;

    ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT(TMO), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .bus(bus), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         push;
        bit         err;
        logic [7:0] b;
    } pend_t;

    pend_t      pend[$];
    logic [7:0] q[$];
    logic [7:0] popped[$];
    logic [7:0] last_data = 8'h00;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         err_seen = 0, err_exp = 0, ovf_seen = 0, ovf_exp = 0;
    bit         ready_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: applies model events once the DUT has had time to react, then checks every cycle.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                q.delete();
                last_data = 8'h00;
                rx_ready  = 1'b0;
                chk("rst_valid", 32'(bus.rx_valid), 32'd0);
                chk("rst_level", 32'(bus.fifo_level), 32'd0);
                chk("rst_data", 32'(bus.rx_data), 32'h00);
                chk("rst_ferr", 32'(frame_err), 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
            end else begin
                if (frame_err) err_seen++;
                if (overflow)  ovf_seen++;
                while (pend.size() != 0 && cyc >= pend[0].due) begin
                    p = pend.pop_front();
                    if (p.err) err_exp++;
                    if (p.push) begin
                        if (q.size() == DEPTH) ovf_exp++;
                        else q.push_back(p.b);
                    end
                end
                if (pend.size() == 0) begin
                    chk("valid", 32'(bus.rx_valid), 32'(q.size() != 0));
                    chk("level", 32'(bus.fifo_level), 32'(q.size()));
                    chk("data", 32'(bus.rx_data), 32'((q.size() != 0) ? q[0] : last_data));
                    chk("ferr_cnt", 32'(err_seen), 32'(err_exp));
                    chk("ovf_cnt", 32'(ovf_seen), 32'(ovf_exp));
                end
                rx_ready = ready_en && (pend.size() == 0) && ($urandom_range(0, 1) == 1);
                if (rx_ready && q.size() != 0) begin
                    last_data = q[0];
                    popped.push_back(q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_settled(input int bound);
        int k = 0;
        while (pend.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("settle_timeout", 32'(pend.size()), 32'd0);
        wait_cyc(2);
    endtask

    task automatic drain();
        int k = 0;
        ready_en = 1'b1;
        while ((q.size() != 0 || pend.size() != 0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        ready_en = 1'b0;
        chk("drain_timeout", 32'(q.size()), 32'd0);
        wait_cyc(3);
    endtask

    // Drives nbits of an 11-bit frame; data changes while ps2_clk is high, half a bit period before the fall.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit bad_start, input int nbits, input bit glitch,
                              input bit expect_to);
        logic [10:0] bits;
        int          h;
        bit          ok;
        pend_t       p;
        bits[0]   = bad_start;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        ok        = bits[10] && ((^bits[9:1]) == 1'b1);
        for (int i = 0; i < nbits; i++) begin
            h = int'($urandom_range(30, 50));
            ps2_data = bits[i];
            if (glitch && i == 4) begin
                wait_cyc(h / 2);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(h - h / 2 - 3);
            end else begin
                wait_cyc(h);
            end
            ps2_clk = 1'b0;
            if (i == 0 && bad_start) begin
                p = '{due: cyc + SETTLE, push: 1'b0, err: 1'b1, b: b};
                pend.push_back(p);
            end else if (i == 10) begin
                p = '{due: cyc + SETTLE, push: ok, err: !ok, b: b};
                pend.push_back(p);
            end
            wait_cyc(h);
            ps2_clk = 1'b1;
            if (bad_start) break;
        end
        if (expect_to) begin
            p = '{due: cyc + int'(TMO) + 40, push: 1'b0, err: 1'b1, b: b};
            pend.push_back(p);
        end
        wait_cyc(10);
        ps2_data = 1'b1;
        wait_cyc(40);
    endtask

    initial begin
        int e0, o0;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(20);

        // 1: single good frame, held in FIFO
        send_frame(8'h1C, 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t1_valid", 32'(bus.rx_valid), 32'd1);
        chk("t1_data", 32'(bus.rx_data), 32'h1C);
        chk("t1_level", 32'(bus.fifo_level), 32'd1);
        drain();

        // 2: parity error
        e0 = err_seen;
        send_frame(8'h1C, 1, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t2_ferr", 32'(err_seen - e0), 32'd1);
        chk("t2_valid", 32'(bus.rx_valid), 32'd0);
        chk("t2_level", 32'(bus.fifo_level), 32'd0);

        // 3: two frames queued, then read in order
        popped.delete();
        send_frame(8'hF0, 0, 0, 0, 11, 0, 0);
        send_frame(8'h1C, 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t3_level", 32'(bus.fifo_level), 32'd2);
        chk("t3_head", 32'(bus.rx_data), 32'hF0);
        drain();
        chk("t3_cnt", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            chk("t3_first", 32'(popped[0]), 32'hF0);
            chk("t3_second", 32'(popped[1]), 32'h1C);
        end

        // 4: overflow on the ninth byte
        popped.delete();
        o0 = ovf_seen;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t4_level", 32'(bus.fifo_level), 32'd8);
        chk("t4_ovf", 32'(ovf_seen - o0), 32'd1);
        drain();
        for (int i = 0; i < 8; i++)
            chk("t4_drain", 32'((popped.size() > i) ? popped[i] : 8'hxx), 32'(i + 1));

        // 5: timeout mid-frame, then a clean frame
        e0 = err_seen;
        send_frame(8'h33, 0, 0, 0, 6, 0, 1);
        wait_settled(int'(TMO) + 200);
        chk("t5_ferr", 32'(err_seen - e0), 32'd1);
        send_frame(8'h5A, 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t5_data", 32'(bus.rx_data), 32'h5A);
        drain();

        // 6: glitch on ps2_clk mid-frame
        send_frame(8'hA5, 0, 0, 0, 11, 1, 0);
        wait_settled(200);
        chk("t6_data", 32'(bus.rx_data), 32'hA5);
        chk("t6_level", 32'(bus.fifo_level), 32'd1);
        drain();

        // start bit high: one error pulse, FSM stays idle
        e0 = err_seen;
        send_frame(8'hFF, 0, 0, 1, 11, 0, 0);
        wait_settled(200);
        chk("start_ferr", 32'(err_seen - e0), 32'd1);

        // 7: reset mid-frame with two bytes queued
        send_frame(8'h11, 0, 0, 0, 11, 0, 0);
        send_frame(8'h22, 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t7_level", 32'(bus.fifo_level), 32'd2);
        send_frame(8'h44, 0, 0, 0, 4, 0, 0);
        reset = 1'b0;
        wait_cyc(2);
        chk("t7_rst_level", 32'(bus.fifo_level), 32'd0);
        chk("t7_rst_data", 32'(bus.rx_data), 32'h00);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(20);
        send_frame(8'h29, 0, 0, 0, 11, 0, 0);
        wait_settled(200);
        chk("t7_data", 32'(bus.rx_data), 32'h29);
        chk("t7_level2", 32'(bus.fifo_level), 32'd1);
        drain();

        // random frames with random consumer back-pressure
        for (int n = 0; n < 24; n++) begin
            ready_en = ($urandom_range(0, 2) != 0);
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 11) == 0), 11, ($urandom_range(0, 3) == 0), 0);
            wait_settled(200);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
